unit_input_buf: RTL and testbench

UNIT_INPUT_BUF -- requirements
Module: unit_input_buf

---
 rtl/unit_input_buf.sv | 225 ++++++++++++++++++++++
 tb/tb_unit_input_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_input_buf.sv
// Per-unit input buffer: byte FIFO from the transmit arbiter, followed by a packet
// parser that packs data bytes into 32-bit little-endian words for the unit data memory.
module unit_input_buf #(
  parameter int WORD_MAX_LEN = 64,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [7:0]  unit_in,
  input  logic        unit_in_ctrl,
  input  logic        unit_in_wr_en,
  output logic        unit_in_afull,
  output logic        unit_in_ready,
  output logic        mem_wr_en,
  output logic [4:0]  mem_wr_addr,
  output logic [31:0] mem_din,
  output logic [6:0]  key_len,
  output logic        pkt_done,
  input  logic        mem_release,
  output logic [4:0]  entry_pts,
  output logic        entry_pts_valid,
  output logic        err,
  output logic [2:0]  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [7:0]    MAX_LEN8  = 8'(WORD_MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR_CHECK = 3'd1,
    S_DATA      = 3'd2,
    S_FULL      = 3'd3,
    S_DISCARD   = 3'd4
  } state_t;

  // Byte FIFO: entries are {ctrl, byte}
  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty, fifo_full, push, pop, overflow;
  logic [8:0]    head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign push       = unit_in_wr_en && !fifo_full;
  assign overflow   = unit_in_wr_en && fifo_full;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {unit_in_ctrl, unit_in};
  end

  // Parser state
  state_t      state_q, state_d;
  logic [8:0]  hdr_q, hdr_d;
  logic [6:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [6:0]  key_len_q, key_len_d;
  logic [4:0]  pts_q, pts_d;
  logic        pts_valid_q, pts_valid_d;
  logic        err_q, err_set;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        done_pend_q, done_pend_d;
  logic        pkt_done_q;
  logic        afull_q, ready_q;

  logic [6:0] key_ceil, last_idx;
  logic       at_last, bad;

  // Key length rounded up to a multiple of 8; only meaningful past byte 32
  assign key_ceil = (key_len_q + 7'd7) & 7'h78;
  assign last_idx = 7'd39 + key_ceil;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    hdr_d       = hdr_q;
    idx_d       = idx_q;
    word_d      = word_q;
    key_len_d   = key_len_q;
    pts_d       = pts_q;
    pts_valid_d = pts_valid_q;
    err_set     = 1'b0;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    done_pend_d = 1'b0;
    at_last     = (idx_q > 7'd32) && (idx_q == last_idx);
    bad         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hdr_d   = head;
          state_d = S_HDR_CHECK;
        end
      end
      S_HDR_CHECK: begin
        if (!hdr_q[8]) begin
          err_set = 1'b1;
          state_d = S_DISCARD;
        end else if (hdr_q[2:0] == 3'b001) begin
          pts_d       = hdr_q[7:3];
          pts_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (hdr_q[2:0] == 3'b000) begin
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          idx_d = idx_q + 7'd1;
          word_d[{idx_q[1:0], 3'b000} +: 8] = head[7:0];
          if (idx_q[1:0] == 2'd3) begin
            wr_en_d = 1'b1;
            addr_d  = idx_q[6:2];
            din_d   = {head[7:0], word_q[23:0]};
          end
          if (idx_q == 7'd32) begin
            key_len_d = head[6:0];
            if (head[7:0] > MAX_LEN8) bad = 1'b1;
          end
          if (head[8] && !at_last) bad = 1'b1;
          if (!head[8] && at_last) bad = 1'b1;
          if ((idx_q > 7'd32) && (idx_q > last_idx)) bad = 1'b1;
          if (bad) begin
            err_set = 1'b1;
            // A framing byte already ends the bad packet; discarding would eat the next header
            state_d = head[8] ? S_IDLE : S_DISCARD;
          end else if (head[8] && at_last) begin
            done_pend_d = 1'b1;
            state_d     = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (mem_release) state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[8]) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      key_len_q   <= '0;
      pts_q       <= '0;
      pts_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      done_pend_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      afull_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      key_len_q   <= key_len_d;
      pts_q       <= pts_d;
      pts_valid_q <= pts_valid_d;
      err_q       <= err_q | err_set | overflow;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      done_pend_q <= done_pend_d;
      // pkt_done trails the final word write by one cycle
      pkt_done_q  <= done_pend_q;
      afull_q     <= (count_d >= AFULL_CNT);
      ready_q     <= (state_d == S_IDLE) && (count_d == '0) && !unit_in_wr_en;
    end
  end

  assign unit_in_afull   = afull_q;
  assign unit_in_ready   = ready_q;
  assign mem_wr_en       = wr_en_q;
  assign mem_wr_addr     = addr_q;
  assign mem_din         = din_q;
  assign key_len         = key_len_q;
  assign pkt_done        = pkt_done_q;
  assign entry_pts       = pts_q;
  assign entry_pts_valid = pts_valid_q;
  assign err             = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_unit_input_buf.sv
// Scoreboard bench for unit_input_buf: stimulus pushes expected word writes and key
// lengths into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_unit_input_buf;

  logic        CLK, rst;
  logic [7:0]  unit_in;
  logic        unit_in_ctrl, unit_in_wr_en, mem_release;
  logic        unit_in_afull, unit_in_ready, mem_wr_en, pkt_done, entry_pts_valid, err;
  logic [4:0]  mem_wr_addr, entry_pts;
  logic [31:0] mem_din;
  logic [6:0]  key_len;
  logic [2:0]  dbg_state_o;

  unit_input_buf dut (
    .CLK(CLK), .rst(rst), .unit_in(unit_in), .unit_in_ctrl(unit_in_ctrl),
    .unit_in_wr_en(unit_in_wr_en), .unit_in_afull(unit_in_afull),
    .unit_in_ready(unit_in_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_din(mem_din), .key_len(key_len), .pkt_done(pkt_done),
    .mem_release(mem_release), .entry_pts(entry_pts),
    .entry_pts_valid(entry_pts_valid), .err(err), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  stim_q[$];
  logic [36:0] exp_q[$];
  logic [6:0]  exp_kl_q[$];
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] word_at10 = '0;
  logic [3:0]  afull_hist = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    afull_hist <= {afull_hist[2:0], unit_in_afull};
    if (!rst && mem_wr_en) begin
      wr_cnt++;
      if (mem_wr_addr == 5'd10) word_at10 = mem_din;
      if (exp_q.size() == 0) check("unexpected_write", {27'd0, mem_wr_addr, mem_din}, 64'd0);
      else check("mem_write", {27'd0, mem_wr_addr, mem_din}, {27'd0, exp_q.pop_front()});
    end
    if (!rst && pkt_done) begin
      done_cnt++;
      if (exp_kl_q.size() == 0) check("unexpected_pkt_done", 64'd1, 64'd0);
      else check("key_len_at_done", {57'd0, key_len}, {57'd0, exp_kl_q.pop_front()});
    end
  end

  // Driver tasks
  task automatic build_pkt(input logic [7:0] kl, input int last_i, input bit valid,
                           input bit ctrl_end);
    logic [31:0] w;
    logic [7:0]  b;
    stim_q.push_back({1'b1, 8'h00});
    w = '0;
    for (int i = 0; i <= last_i; i++) begin
      if (i == 32)      b = kl;
      else if (i >= 40) b = 8'h41 + 8'(i - 40);
      else              b = 8'(i * 3 + 16);
      stim_q.push_back({(ctrl_end && i == last_i), b});
      w[8*(i%4) +: 8] = b;
      if (i % 4 == 3) exp_q.push_back({5'(i / 4), w});
    end
    if (valid) exp_kl_q.push_back(kl[6:0]);
  endtask

  task automatic drive_all(input bit throttle);
    logic [8:0] e;
    int guard = 0;
    while (stim_q.size() > 0 && guard < 3000) begin
      @(posedge CLK); #1;
      guard++;
      if (throttle && afull_hist[2]) unit_in_wr_en = 1'b0;
      else begin
        e = stim_q.pop_front();
        unit_in_ctrl  = e[8];
        unit_in       = e[7:0];
        unit_in_wr_en = 1'b1;
      end
    end
    @(posedge CLK); #1;
    unit_in_wr_en = 1'b0;
    if (stim_q.size() > 0) check("driver_timeout", 64'(stim_q.size()), 64'd0);
    stim_q.delete();
  endtask

  task automatic push_raw(input logic [7:0] b);
    @(posedge CLK); #1;
    unit_in_ctrl = 1'b0; unit_in = b; unit_in_wr_en = 1'b1;
    @(posedge CLK); #1;
    unit_in_wr_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 2000) begin
      @(posedge CLK);
      g++;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("pkt_done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic release_pkt();
    @(posedge CLK); #1 mem_release = 1'b1;
    @(posedge CLK); #1 mem_release = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 rst = 1'b1; unit_in_wr_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    @(negedge CLK);
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; unit_in = '0; unit_in_ctrl = 1'b0; unit_in_wr_en = 1'b0; mem_release = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    @(negedge CLK);
    check("rst_afull", 64'(unit_in_afull), 64'd0);
    check("rst_ready", 64'(unit_in_ready), 64'd1);
    check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
    check("rst_mem_din", 64'(mem_din), 64'd0);
    check("rst_key_len", 64'(key_len), 64'd0);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    check("rst_entry_pts", 64'(entry_pts), 64'd0);
    check("rst_entry_pts_valid", 64'(entry_pts_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state_idle", 64'(dbg_state_o), 64'd0);

    // Init header 0xA9 twice: pts = 0xA9 >> 3 = 21
    stim_q.push_back({1'b1, 8'hA9});
    stim_q.push_back({1'b1, 8'hA9});
    drive_all(1'b0);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("init_entry_pts", 64'(entry_pts), 64'd21);
    check("init_entry_pts_valid", 64'(entry_pts_valid), 64'd1);
    check("init_err", 64'(err), 64'd0);
    check("init_no_writes", 64'(wr_cnt), 64'd0);
    check("init_ready", 64'(unit_in_ready), 64'd1);

    // Basic packet: key_len 5, L = 47, key bytes 'A'..'H' at 40..47
    build_pkt(8'd5, 47, 1'b1, 1'b1);
    drive_all(1'b0);
    wait_done(1);
    check("p1_write_count", 64'(wr_cnt), 64'd12);
    check("p1_addr10_word", 64'(word_at10), 64'h44434241);
    check("p1_key_len", 64'(key_len), 64'd5);
    check("p1_state_full", 64'(dbg_state_o), 64'd3);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("p1_ready_held_low", 64'(unit_in_ready), 64'd0);
    release_pkt();
    @(negedge CLK);
    check("p1_ready_after_release", 64'(unit_in_ready), 64'd1);

    // Two back-to-back 64-byte-key packets with the core stalled on the first
    build_pkt(8'd64, 103, 1'b1, 1'b1);
    build_pkt(8'd64, 103, 1'b1, 1'b1);
    fork
      drive_all(1'b1);
      begin
        wait_done(2);
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        check("stall_afull", 64'(unit_in_afull), 64'd1);
        check("stall_no_overflow", 64'(err), 64'd0);
        check("stall_ready", 64'(unit_in_ready), 64'd0);
        check("stall_state_full", 64'(dbg_state_o), 64'd3);
        release_pkt();
      end
    join
    wait_done(3);
    check("b2b_err", 64'(err), 64'd0);
    check("b2b_key_len", 64'(key_len), 64'd64);
    release_pkt();

    // Early ctrl (byte 47 with L = 55), then a valid packet
    build_pkt(8'd9, 47, 1'b0, 1'b1);
    build_pkt(8'd5, 47, 1'b1, 1'b1);
    drive_all(1'b0);
    wait_done(4);
    check("early_ctrl_err", 64'(err), 64'd1);
    check("after_err_key_len", 64'(key_len), 64'd5);
    release_pkt();

    // Reset mid-packet after byte 20
    build_pkt(8'd0, 20, 1'b0, 1'b0);
    drive_all(1'b0);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("mid_state_data", 64'(dbg_state_o), 64'd2);
    check("err_sticky", 64'(err), 64'd1);
    do_reset();
    check("mid_rst_state", 64'(dbg_state_o), 64'd0);
    check("mid_rst_ready", 64'(unit_in_ready), 64'd1);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_key_len", 64'(key_len), 64'd0);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("mid_rst_no_done", 64'(done_cnt), 64'd4);
    build_pkt(8'd5, 47, 1'b1, 1'b1);
    drive_all(1'b0);
    wait_done(5);
    check("fresh_key_len", 64'(key_len), 64'd5);
    check("fresh_err", 64'(err), 64'd0);

    // Fill the FIFO while parked in FULL: afull at 12, drop on the 17th push
    for (int k = 1; k <= 17; k++) begin
      push_raw(8'(k));
      if (k == 11) check("afull_at_11", 64'(unit_in_afull), 64'd0);
      if (k == 12) check("afull_at_12", 64'(unit_in_afull), 64'd1);
      if (k == 16) check("no_err_at_16", 64'(err), 64'd0);
      if (k == 17) check("overflow_err", 64'(err), 64'd1);
    end
    do_reset();
    check("final_rst_afull", 64'(unit_in_afull), 64'd0);
    check("final_rst_ready", 64'(unit_in_ready), 64'd1);

    check("exp_writes_drained", 64'(exp_q.size()), 64'd0);
    check("exp_done_drained", 64'(exp_kl_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
